// File: rtl/lcd_hd44780_ctrl.sv
// Replays 32-bit LCD register writes onto an HD44780-style 8-bit parallel bus
// with setup/enable/hold/execution timing and a one-entry holding buffer.
//
// state | meaning
// ------+-----------------------------------------------------------
// PWRUP | bus idle after reset while the panel powers up
// IDLE  | waiting for a buffered or direct write to launch
// SETUP | rs/data valid, en low (address setup)
// PULSE | en high
// HOLD  | en low, rs/data held
// WAIT  | command execution time before the next launch
module lcd_hd44780_ctrl #(
  parameter int unsigned POWERUP_CYC   = 750000,
  parameter int unsigned SETUP_CYC     = 2,
  parameter int unsigned PULSE_CYC     = 12,
  parameter int unsigned HOLD_CYC      = 2,
  parameter int unsigned EXEC_CYC      = 2000,
  parameter int unsigned EXEC_LONG_CYC = 82000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lcd_wr_i,
  input  logic [31:0] lcd_word_i,
  output logic        lcd_busy_o,
  output logic        lcd_full_o,
  output logic        lcd_ovf_o,
  output logic        lcd_on_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic [7:0]  lcd_data_o
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAX_CYC = max2(max2(max2(POWERUP_CYC, SETUP_CYC),
                                              max2(PULSE_CYC, HOLD_CYC)),
                                         max2(EXEC_CYC, EXEC_LONG_CYC));
  localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_last;
  logic          phase_last;

  // Buffer entry layout: {on, rs, data}
  logic [9:0]    buf_word_q;
  logic          buf_full_q, buf_full_d;
  logic          ovf_q;

  logic          on_q, rs_q, long_q;
  logic [7:0]    data_q;

  logic          launch_buf, launch_dir, launch;
  logic          store, drop;
  logic [9:0]    in_word, launch_word;
  logic          launch_long;

  logic          unused_word_bits;
  assign unused_word_bits = ^{lcd_word_i[30:11], lcd_word_i[9:8]};

  assign in_word = {lcd_word_i[31], lcd_word_i[10], lcd_word_i[7:0]};

  always_comb begin
    cnt_last = '0;
    case (state_q)
      ST_PWRUP: cnt_last = CW'(POWERUP_CYC - 1);
      ST_SETUP: cnt_last = CW'(SETUP_CYC - 1);
      ST_PULSE: cnt_last = CW'(PULSE_CYC - 1);
      ST_HOLD:  cnt_last = CW'(HOLD_CYC - 1);
      ST_WAIT:  cnt_last = long_q ? CW'(EXEC_LONG_CYC - 1) : CW'(EXEC_CYC - 1);
      default:  cnt_last = '0;
    endcase
  end

  assign phase_last = (cnt_q == cnt_last);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    launch_buf = 1'b0;
    launch_dir = 1'b0;
    case (state_q)
      ST_PWRUP: begin
        if (phase_last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (buf_full_q) launch_buf = 1'b1;
        else if (lcd_wr_i) launch_dir = 1'b1;
      end
      ST_SETUP: begin
        if (phase_last) begin
          state_d = ST_PULSE;
          cnt_d   = '0;
        end
      end
      ST_PULSE: begin
        if (phase_last) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (phase_last) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (phase_last) begin
          cnt_d = '0;
          if (buf_full_q) launch_buf = 1'b1;
          else state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_PWRUP;
        cnt_d   = '0;
      end
    endcase
    if (launch_buf || launch_dir) begin
      state_d = ST_SETUP;
      cnt_d   = '0;
    end
  end

  assign launch      = launch_buf | launch_dir;
  assign launch_word = launch_buf ? buf_word_q : in_word;
  assign launch_long = ~launch_word[8] &
                       ((launch_word[7:0] == 8'h01) | (launch_word[7:0] == 8'h02));

  // A write that lands while the buffer is being launched refills it.
  assign store = lcd_wr_i & ~launch_dir & (~buf_full_q | launch_buf);
  assign drop  = lcd_wr_i & ~launch_dir & buf_full_q & ~launch_buf;

  always_comb begin
    buf_full_d = buf_full_q;
    if (store) buf_full_d = 1'b1;
    else if (launch_buf) buf_full_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_PWRUP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_full_q <= 1'b0;
      buf_word_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      buf_full_q <= buf_full_d;
      if (store) buf_word_q <= in_word;
      if (drop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      on_q   <= 1'b0;
      rs_q   <= 1'b0;
      data_q <= 8'h00;
      long_q <= 1'b0;
    end else if (launch) begin
      on_q   <= launch_word[9];
      rs_q   <= launch_word[8];
      data_q <= launch_word[7:0];
      long_q <= launch_long;
    end
  end

  assign lcd_busy_o = (state_q != ST_IDLE) | buf_full_q;
  assign lcd_full_o = buf_full_q;
  assign lcd_ovf_o  = ovf_q;
  assign lcd_on_o   = on_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_rw_o   = 1'b0;
  assign lcd_en_o   = (state_q == ST_PULSE);
  assign lcd_data_o = data_q;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Scoreboard bench: stimulus queues expected bus transfers, a monitor pops
// and checks each transfer's bus value, enable width and execution wait.
module tb_lcd_hd44780_ctrl;

  localparam int PWR   = 20;
  localparam int SET   = 2;
  localparam int PUL   = 4;
  localparam int HLD   = 2;
  localparam int EXE   = 10;
  localparam int EXE_L = 40;

  logic        clk;
  logic        rst_n;
  logic        wr;
  logic [31:0] word;
  logic        busy, full, ovf, on, rs, rw, en;
  logic [7:0]  data;

  lcd_hd44780_ctrl #(
    .POWERUP_CYC(PWR), .SETUP_CYC(SET), .PULSE_CYC(PUL),
    .HOLD_CYC(HLD), .EXEC_CYC(EXE), .EXEC_LONG_CYC(EXE_L)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .lcd_wr_i(wr), .lcd_word_i(word),
    .lcd_busy_o(busy), .lcd_full_o(full), .lcd_ovf_o(ovf), .lcd_on_o(on),
    .lcd_rs_o(rs), .lcd_rw_o(rw), .lcd_en_o(en), .lcd_data_o(data)
  );

  typedef struct {
    logic       on;
    logic       rs;
    logic [7:0] data;
    int         pulse;
    int         wlen;
  } xfer_t;

  xfer_t exp_q[$];
  int total = 0;
  int bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic o, input logic r, input logic [7:0] d, input int w);
    xfer_t e;
    e.on = o; e.rs = r; e.data = d; e.pulse = PUL; e.wlen = w;
    exp_q.push_back(e);
  endtask

  // Call at a negedge: the following posedge samples the write.
  task automatic drive(input logic [31:0] w);
    wr = 1'b1;
    word = w;
    @(negedge clk);
    wr = 1'b0;
    word = 32'h0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || full) && n < 1000);
    check("idle_reached", {30'd0, full, busy}, 32'd0);
  endtask

  task automatic powerup_check();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy && n < 100);
    check("pwrup_len", n, PWR);
    check("pwrup_bus", {on, rs, rw, en, data}, 12'h000);
  endtask

  // Monitor
  logic       m_en_prev = 1'b0;
  logic       m_in_gap  = 1'b0;
  int         m_high    = 0;
  int         m_gap     = 0;
  logic       m_on, m_rs;
  logic [7:0] m_data;

  task automatic finalize(input int wlen);
    xfer_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_xfer: got data %0h want no transfer", m_data);
    end else begin
      e = exp_q.pop_front();
      check("xfer_on", m_on, e.on);
      check("xfer_rs", m_rs, e.rs);
      check("xfer_data", m_data, e.data);
      check("xfer_pulse", m_high, e.pulse);
      check("xfer_wait", wlen, e.wlen);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      m_en_prev = 1'b0;
      m_in_gap  = 1'b0;
      m_high    = 0;
      m_gap     = 0;
    end else begin
      if (en && !m_en_prev) begin
        if (m_in_gap) finalize(m_gap - HLD - SET);
        m_on = on; m_rs = rs; m_data = data;
        m_high = 1;
        m_in_gap = 1'b0;
      end else if (en) begin
        m_high++;
      end else if (m_en_prev) begin
        m_in_gap = 1'b1;
        m_gap = 1;
      end else if (m_in_gap) begin
        if (!busy) begin
          finalize(m_gap - HLD);
          m_in_gap = 1'b0;
        end else begin
          m_gap++;
        end
      end
      m_en_prev = en;
    end
  end

  initial begin
    rst_n = 1'b0;
    wr = 1'b0;
    word = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b1);
    check("rst_full_ovf", {full, ovf}, 2'b00);
    check("rst_bus", {on, rs, rw, en, data}, 12'h000);
    rst_n = 1'b1;
    powerup_check();

    // Direct write with latency checks
    @(negedge clk);
    push(1'b1, 1'b1, 8'h41, EXE);
    drive(32'h8000_0441);
    check("lat_bus", {on, rs, data}, {1'b1, 1'b1, 8'h41});
    check("lat_busy", busy, 1'b1);
    check("lat_en_c1", en, 1'b0);
    @(negedge clk);
    check("lat_en_c2", en, 1'b0);
    @(negedge clk);
    check("lat_en_c3", en, 1'b1);
    wait_idle();

    // Long and short execution waits
    push(1'b1, 1'b0, 8'h01, EXE_L);
    drive(32'h8000_0001);
    wait_idle();
    push(1'b1, 1'b0, 8'h03, EXE);
    drive(32'h8000_0003);
    wait_idle();
    push(1'b0, 1'b0, 8'h02, EXE_L);
    drive(32'h0000_0002);
    wait_idle();
    push(1'b1, 1'b1, 8'h02, EXE);
    drive(32'h8000_0402);
    wait_idle();

    // Write on the exact cycle the buffer launches
    push(1'b1, 1'b1, 8'h31, EXE);
    push(1'b1, 1'b1, 8'h32, EXE);
    push(1'b1, 1'b1, 8'h33, EXE);
    drive(32'h8000_0431);
    drive(32'h8000_0432);
    check("coin_full_pre", full, 1'b1);
    repeat (16) @(negedge clk);
    drive(32'h8000_0433);
    check("coin_full", full, 1'b1);
    check("coin_ovf", ovf, 1'b0);
    check("coin_bus", data, 8'h32);
    wait_idle();

    // Back-to-back A, B, C: C is dropped
    push(1'b1, 1'b1, 8'h55, EXE);
    push(1'b1, 1'b1, 8'h66, EXE);
    drive(32'h8000_0455);
    drive(32'h8000_0466);
    drive(32'h8000_0477);
    check("abc_full", full, 1'b1);
    check("abc_ovf", ovf, 1'b1);
    check("abc_bus", data, 8'h55);
    wait_idle();
    check("abc_ovf_sticky", ovf, 1'b1);

    // Reset during PULSE with a buffered word pending
    drive(32'h8000_0458);
    drive(32'h8000_0459);
    @(negedge clk);
    check("rst_en_before", en, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_en", en, 1'b0);
    check("midrst_full", full, 1'b0);
    check("midrst_ovf", ovf, 1'b0);
    check("midrst_busy", busy, 1'b1);
    check("midrst_bus", {on, rs, data}, 10'h000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    powerup_check();

    @(negedge clk);
    push(1'b1, 1'b1, 8'h48, EXE);
    drive(32'h8000_0448);
    wait_idle();
    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
